// File: rtl/float_pkg.sv
// Shared IEEE-754 binary64 field definitions and the pipeline stage records used
// by the float-to-fixed converter.
package float_pkg;

  localparam int F64_EXP_BIAS = 1023;
  localparam int F64_EXP_W    = 11;
  localparam int F64_MAN_W    = 52;
  localparam int FX_W         = 64;
  localparam int SHAMT_W      = 6;

  typedef struct packed {
    logic                 sign;
    logic [F64_EXP_W-1:0] exp;
    logic [F64_MAN_W-1:0] man;
  } f64_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
  } fx_flags_t;

  // Result class decided in S2; everything but CLS_NORM is a fixed output pattern.
  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_NAN,
    CLS_SAT_POS,
    CLS_SAT_NEG,
    CLS_MIN_NEG
  } fx_cls_e;

  typedef struct packed {
    logic                        sign;
    logic                        zero;
    logic                        inf;
    logic                        nan;
    logic signed [F64_EXP_W:0]   exp;
    logic [F64_MAN_W-1:0]        man;
  } s1_t;

  typedef struct packed {
    fx_cls_e              cls;
    logic                 sign;
    logic                 left;
    logic [SHAMT_W-1:0]   amt;
    logic [F64_MAN_W-1:0] man;
  } s2_t;

  typedef struct packed {
    fx_cls_e         cls;
    logic            sign;
    logic [FX_W-1:0] mag;
  } s3_t;

  function automatic fx_flags_t cls_flags(input fx_cls_e c);
    fx_flags_t f;
    f.invalid  = (c == CLS_NAN);
    f.overflow = (c == CLS_SAT_POS) || (c == CLS_SAT_NEG);
    return f;
  endfunction

endpackage

// File: rtl/f64_classify.sv
// Combinational binary64 classifier: zero/subnormal/inf/NaN detection and the
// unbiased exponent as a signed value.
module f64_classify
  import float_pkg::*;
(
  input  f64_t                      f,
  output logic                      is_neg,
  output logic                      is_zero,
  output logic                      is_sub,
  output logic                      is_inf,
  output logic                      is_nan,
  output logic signed [F64_EXP_W:0] unb_exp
);

  logic exp_min;
  logic exp_max;
  logic man_nz;

  assign exp_min = (f.exp == '0);
  assign exp_max = &f.exp;
  assign man_nz  = |f.man;

  assign is_neg  = f.sign;
  assign is_zero = exp_min & ~man_nz;
  assign is_sub  = exp_min &  man_nz;
  assign is_inf  = exp_max & ~man_nz;
  assign is_nan  = exp_max &  man_nz;

  assign unb_exp = $signed({1'b0, f.exp}) - $signed((F64_EXP_W+1)'(F64_EXP_BIAS));

endmodule

// File: rtl/float_to_fixed.sv
// binary64 -> signed 64-bit fixed point (FRAC_BITS fraction), truncating, saturating.
// Four register stages, 4-cycle latency; the whole pipe stalls when the output is held.
module float_to_fixed
  import float_pkg::*;
#(
  parameter int FRAC_BITS = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] s_axis_a_tdata,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  output logic [63:0] m_axis_result_tdata,
  output logic [1:0]  m_axis_result_tuser,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready
);

  localparam int ESUM_W = 14;

  logic advance;
  logic s1_vld, s2_vld, s3_vld;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;

  logic [FX_W-1:0] out_dat;
  fx_flags_t       out_flags;

  assign advance         = m_axis_result_tready | ~m_axis_result_tvalid;
  assign s_axis_a_tready = advance;

  // S1: unpack and classify
  f64_t                      in_f;
  logic                      c_neg, c_zero, c_sub, c_inf, c_nan;
  logic signed [F64_EXP_W:0] c_exp;

  assign in_f = f64_t'(s_axis_a_tdata);

  f64_classify u_classify (
    .f       (in_f),
    .is_neg  (c_neg),
    .is_zero (c_zero),
    .is_sub  (c_sub),
    .is_inf  (c_inf),
    .is_nan  (c_nan),
    .unb_exp (c_exp)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.sign = c_neg;
    s1_d.zero = c_zero | c_sub;
    s1_d.inf  = c_inf;
    s1_d.nan  = c_nan;
    s1_d.exp  = c_exp;
    s1_d.man  = in_f.man;
  end

  // S2: scaled exponent, shift direction/amount and special-case class
  logic signed [ESUM_W-1:0] e_sum;
  logic signed [ESUM_W-1:0] k;
  logic signed [ESUM_W-1:0] k_neg;

  assign e_sum = $signed({{(ESUM_W-F64_EXP_W-1){s1_q.exp[F64_EXP_W]}}, s1_q.exp})
               + $signed(ESUM_W'(FRAC_BITS));
  assign k     = e_sum - $signed(ESUM_W'(F64_MAN_W));
  assign k_neg = -k;

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.man  = s1_q.man;
    s2_d.left = ~k[ESUM_W-1];
    s2_d.amt  = k[ESUM_W-1] ? k_neg[SHAMT_W-1:0] : k[SHAMT_W-1:0];
    s2_d.cls  = CLS_NORM;
    if (s1_q.nan) begin
      s2_d.cls = CLS_NAN;
    end else if (s1_q.zero) begin
      s2_d.cls = CLS_ZERO;
    end else if (s1_q.inf) begin
      s2_d.cls = s1_q.sign ? CLS_SAT_NEG : CLS_SAT_POS;
    end else if (e_sum >= $signed(ESUM_W'(63))) begin
      // -2^63 is the one magnitude at 2^63 that still fits
      if (s1_q.sign && (e_sum == $signed(ESUM_W'(63))) && (s1_q.man == '0))
        s2_d.cls = CLS_MIN_NEG;
      else
        s2_d.cls = s1_q.sign ? CLS_SAT_NEG : CLS_SAT_POS;
    end else if (k < -$signed(ESUM_W'(F64_MAN_W))) begin
      s2_d.cls = CLS_ZERO;
    end
  end

  // S3: barrel shift of the 53-bit significand; left shifts never exceed 10 here
  logic [FX_W-1:0] sig;

  assign sig = {{(FX_W-F64_MAN_W-1){1'b0}}, 1'b1, s2_q.man};

  always_comb begin
    s3_d      = '0;
    s3_d.cls  = s2_q.cls;
    s3_d.sign = s2_q.sign;
    s3_d.mag  = s2_q.left ? (sig << s2_q.amt) : (sig >> s2_q.amt);
  end

  // S4: negate or substitute the saturated/special pattern
  always_comb begin
    out_flags = cls_flags(s3_q.cls);
    out_dat   = '0;
    case (s3_q.cls)
      CLS_NORM:    out_dat = s3_q.sign ? (~s3_q.mag + 64'd1) : s3_q.mag;
      CLS_SAT_POS: out_dat = 64'h7FFF_FFFF_FFFF_FFFF;
      CLS_SAT_NEG: out_dat = 64'h8000_0000_0000_0000;
      CLS_MIN_NEG: out_dat = 64'h8000_0000_0000_0000;
      default:     out_dat = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      s1_vld               <= 1'b0;
      s2_vld               <= 1'b0;
      s3_vld               <= 1'b0;
      m_axis_result_tvalid <= 1'b0;
    end else if (advance) begin
      s1_vld               <= s_axis_a_tvalid;
      s2_vld               <= s1_vld;
      s3_vld               <= s2_vld;
      m_axis_result_tvalid <= s3_vld;
    end
  end

  // Payload registers carry no reset; their contents only matter under a valid bit.
  always_ff @(posedge aclk) begin
    if (advance) begin
      s1_q                <= s1_d;
      s2_q                <= s2_d;
      s3_q                <= s3_d;
      m_axis_result_tdata <= out_dat;
      m_axis_result_tuser <= out_flags;
    end
  end

endmodule

// File: tb/tb_float_to_fixed.sv
// Bench for float_to_fixed: FRAC_BITS=0 and FRAC_BITS=16 instances share one stimulus stream.
module tb_float_to_fixed;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [63:0] in_dat = '0;
  logic        in_vld = 1'b0;
  logic        out_rdy = 1'b1;

  logic        rdy0, rdy16, vld0, vld16;
  logic [63:0] dat0, dat16;
  logic [1:0]  usr0, usr16;

  always #5 aclk = ~aclk;

  float_to_fixed #(.FRAC_BITS(0)) u_f0 (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tdata       (in_dat),
    .s_axis_a_tvalid      (in_vld),
    .s_axis_a_tready      (rdy0),
    .m_axis_result_tdata  (dat0),
    .m_axis_result_tuser  (usr0),
    .m_axis_result_tvalid (vld0),
    .m_axis_result_tready (out_rdy)
  );

  float_to_fixed #(.FRAC_BITS(16)) u_f16 (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tdata       (in_dat),
    .s_axis_a_tvalid      (in_vld),
    .s_axis_a_tready      (rdy16),
    .m_axis_result_tdata  (dat16),
    .m_axis_result_tuser  (usr16),
    .m_axis_result_tvalid (vld16),
    .m_axis_result_tready (out_rdy)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  f;
  } exp_t;

  exp_t q0[$];
  exp_t q16[$];
  int   errors = 0;
  int   checks = 0;
  bit   rand_mode = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: exact real scaling, then truncate toward zero.
  function automatic exp_t model(input logic [63:0] b, input int fb);
    exp_t   e;
    real    r, a, lim;
    longint v;
    lim = 2.0 ** 63;
    if (b[62:52] == 11'h7FF && b[51:0] != 52'd0) begin
      e.d = '0; e.f = 2'b10; return e;
    end
    if (b[62:52] == 11'h000) begin
      e.d = '0; e.f = 2'b00; return e;
    end
    r = $bitstoreal(b) * (2.0 ** fb);
    if (r >= lim) begin
      e.d = 64'h7FFF_FFFF_FFFF_FFFF; e.f = 2'b01;
    end else if (r < -lim) begin
      e.d = 64'h8000_0000_0000_0000; e.f = 2'b01;
    end else if (r == -lim) begin
      e.d = 64'h8000_0000_0000_0000; e.f = 2'b00;
    end else begin
      a   = (r < 0.0) ? -r : r;
      v   = longint'($floor(a));
      e.d = (r < 0.0) ? 64'(-v) : 64'(v);
      e.f = 2'b00;
    end
    return e;
  endfunction

  // Output side: ready pattern, scoreboard pop, stall stability.
  logic [63:0] hold0, hold16;
  logic [1:0]  hu0, hu16;
  bit          stall = 1'b0;

  always @(negedge aclk) begin
    exp_t e;
    if (stall) begin
      chk("hold_dat0", dat0, hold0);
      chk("hold_usr0", 64'(usr0), 64'(hu0));
      chk("hold_dat16", dat16, hold16);
      chk("hold_usr16", 64'(usr16), 64'(hu16));
    end
    out_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (vld0 === 1'b1 && out_rdy) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_out0 observed=%h expected=none", dat0);
      end else begin
        e = q0.pop_front();
        chk("dat0", dat0, e.d);
        chk("usr0", 64'(usr0), 64'(e.f));
      end
    end
    if (vld16 === 1'b1 && out_rdy) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_out16 observed=%h expected=none", dat16);
      end else begin
        e = q16.pop_front();
        chk("dat16", dat16, e.d);
        chk("usr16", 64'(usr16), 64'(e.f));
      end
    end
    stall  = (vld0 === 1'b1 || vld16 === 1'b1) && !out_rdy;
    hold0  = dat0;  hu0  = usr0;
    hold16 = dat16; hu16 = usr16;
  end

  // Present one operand from the next falling edge until accepted; the FRAC_BITS=0
  // expectation is either a stated constant or the model.
  task automatic send(input logic [63:0] b, input bit use_c, input logic [63:0] cd,
                      input logic [1:0] cf);
    exp_t e;
    @(negedge aclk);
    in_dat = b;
    in_vld = 1'b1;
    #1;
    for (int i = 0; i < 100 && !rdy0; i++) begin
      @(negedge aclk);
      #1;
    end
    if (!rdy0) begin
      checks++; errors++;
      $error("FAIL send_timeout observed=tready0=%b expected=1", rdy0);
    end else begin
      e.d = cd;
      e.f = cf;
      q0.push_back(use_c ? e : model(b, 0));
      q16.push_back(model(b, 16));
    end
  endtask

  // Single operand into an empty pipe: tvalid must rise exactly 4 cycles after acceptance.
  task automatic lat_test(input string tag, input logic [63:0] b, input logic [63:0] cd,
                          input logic [1:0] cf);
    send(b, 1'b1, cd, cf);
    @(posedge aclk);
    #1 in_vld = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #1 chk({tag, "_vld_cycle3"}, 64'(vld0), 64'd0);
    @(posedge aclk);
    #1 chk({tag, "_vld_cycle4"}, 64'(vld0), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (q0.size() != 0 || q16.size() != 0); i++)
      @(negedge aclk);
    repeat (8) @(negedge aclk);
    chk({tag, "_left0"}, 64'(q0.size()), 64'd0);
    chk({tag, "_left16"}, 64'(q16.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rw;
    logic [63:0] b;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_vld0", 64'(vld0), 64'd0);
    chk("rst_vld16", 64'(vld16), 64'd0);
    chk("rst_rdy0", 64'(rdy0), 64'd1);
    @(negedge aclk) aresetn = 1'b0;

    // 42.0 with latency measurement
    lat_test("lat42", 64'h4045_0000_0000_0000, 64'h0000_0000_0000_002A, 2'b00);
    drain("d42");

    // Directed values, back to back
    send(64'hC004_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00); // -2.5
    send(64'h3FF8_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0001, 2'b00); // 1.5
    send(64'h43E0_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01); // 2^63
    send(64'hC3E0_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 2'b00); // -2^63
    send(64'hFFF0_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 2'b01); // -inf
    send(64'h7FF0_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 2'b01); // +inf
    send(64'h7FF8_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 2'b10); // NaN
    send(64'h8000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 2'b00); // -0
    send(64'h0000_0000_0000_0001, 1'b1, 64'h0000_0000_0000_0000, 2'b00); // subnormal
    send(64'h43DF_FFFF_FFFF_FFFF, 1'b1, 64'h7FFF_FFFF_FFFF_FC00, 2'b00); // max below 2^63
    send(64'hC3DF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0400, 2'b00);
    send(64'hC3E0_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0000, 2'b01); // just past -2^63
    send(64'h3FEF_FFFF_FFFF_FFFF, 1'b1, 64'h0000_0000_0000_0000, 2'b00); // 0.999..
    send(64'hBFD0_0000_0000_0000, 1'b1, 64'h0000_0000_0000_0000, 2'b00); // -0.25
    @(negedge aclk) in_vld = 1'b0;
    drain("ddir");

    // 16 back-to-back random operands under random ready
    rand_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rw = {32'($urandom), 32'($urandom)};
      b  = {1'($urandom_range(0, 1)), 11'($urandom_range(1023 - 60, 1023 + 66)), rw[51:0]};
      send(b, 1'b0, '0, 2'b00);
    end
    @(negedge aclk) in_vld = 1'b0;
    repeat (20) @(negedge aclk);
    rand_mode = 1'b0;
    drain("drand");

    // Mid-stream reset with three operands in flight
    send(64'h4000_0000_0000_0000, 1'b0, '0, 2'b00);
    send(64'h4010_0000_0000_0000, 1'b0, '0, 2'b00);
    send(64'h4020_0000_0000_0000, 1'b0, '0, 2'b00);
    @(posedge aclk);
    #1;
    in_vld  = 1'b0;
    aresetn = 1'b1;
    q0.delete();
    q16.delete();
    @(negedge aclk);
    chk("inrst_rdy0", 64'(rdy0), 64'd1);
    @(posedge aclk);
    #1;
    chk("postrst_vld0", 64'(vld0), 64'd0);
    chk("postrst_vld16", 64'(vld16), 64'd0);
    chk("postrst_rdy0", 64'(rdy0), 64'd1);
    aresetn = 1'b0;
    lat_test("latrst", 64'hC059_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF9C, 2'b00); // -100.0
    drain("drst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_to_fixed.md
FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 0, meaning the number of fractional bits in the signed output; legal range 0..32.
REQ-002 SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port aresetn, input, 1, synchronous active-high reset; the name is kept for interface uniformity and asserting it high resets the block.
REQ-004 SHALL have port s_axis_a_tdata, input, 64, IEEE-754 binary64 operand.
REQ-005 SHALL have port s_axis_a_tvalid, input, 1, operand valid.
REQ-006 SHALL have port s_axis_a_tready, output, 1, operand accepted when tvalid and tready are both high.
REQ-007 SHALL have port m_axis_result_tdata, output, 64, two's-complement fixed-point result with FRAC_BITS fractional bits.
REQ-008 SHALL have port m_axis_result_tuser, output, 2, status flags: bit0 = overflow (saturated), bit1 = invalid (NaN).
REQ-009 SHALL have port m_axis_result_tvalid, output, 1, result valid.
REQ-010 SHALL have port m_axis_result_tready, input, 1, downstream ready.

Function
REQ-011 SHALL compute result = trunc(x * 2^FRAC_BITS), rounding toward zero.
REQ-012 SHALL return 0 with flags 00 for +0, -0, and all subnormals (exponent field 0).
REQ-013 SHALL return 0 with flags 10 for NaN (exponent 0x7FF, mantissa nonzero).
REQ-014 SHALL saturate to 0x7FFF_FFFF_FFFF_FFFF with flags 01 for positive values, including +inf, when unbiased exponent + FRAC_BITS >= 63.
REQ-015 SHALL saturate to 0x8000_0000_0000_0000 with flags 01 for negative values, including -inf, when unbiased exponent + FRAC_BITS >= 63, except an exact -2^63, which SHALL return 0x8000_0000_0000_0000 with flags 00.
REQ-016 SHALL form magnitude {1, mantissa[51:0]} and apply shift k = unbiased exponent + FRAC_BITS - 52: left shift when k >= 0, right shift discarding bits when k < 0, and magnitude 0 when k <= -53; negative inputs SHALL then be two's-complement negated.
REQ-017 SHALL be a 4-stage pipeline: S1 unpack/classify, S2 shift amount and direction, S3 barrel shift, S4 negate/saturate into output registers; latency is exactly 4 cycles from acceptance to tvalid when never stalled.
REQ-018 SHALL define advance = m_axis_result_tready OR NOT m_axis_result_tvalid; s_axis_a_tready SHALL equal advance (combinational).
REQ-019 SHALL, when advance is high, shift every stage (data, flags, valid) forward by one; when advance is low, all stages SHALL hold.
REQ-020 SHALL hold m_axis_result_tdata and m_axis_result_tuser stable while tvalid is high and tready is low.
REQ-021 SHALL sustain 1 result per cycle with tready held high, with no loss, duplication, or reordering under any tready pattern.
REQ-022 SHALL propagate bubbles (tvalid low inputs) as invalid stages; flags and data of invalid stages are don't-care.

Reset
REQ-023 SHALL clear all stage valid bits when aresetn is high; m_axis_result_tvalid SHALL be 0 on the cycle after reset is sampled.
REQ-024 SHALL give reset priority over advance; in-flight operands SHALL be discarded on a mid-stream reset.
REQ-025 SHALL drive s_axis_a_tready to 1 during and after reset (pipeline empty); data/flag registers need not be reset.

Structure
REQ-026 SHALL place in shared package float_pkg: F64_EXP_BIAS = 1023, F64_EXP_W = 11, F64_MAN_W = 52, and a packed struct f64_t {sign, exp, man}, plus a packed fx_flags_t {invalid, overflow}.
REQ-027 SHALL use one combinational sub-module, f64_classify, that takes f64_t and outputs is_zero, is_sub, is_inf, is_nan, and the unbiased exponent; it is used in S1.

Verification
REQ-028 SHALL test FRAC_BITS=0 with 0x4045000000000000 (42.0): expect 0x000000000000002A and flags 00 exactly 4 cycles later.
REQ-029 SHALL test FRAC_BITS=0 with 0xC004000000000000 (-2.5): expect 0xFFFFFFFFFFFFFFFE; then 0x3FF8000000000000 with FRAC_BITS=16: expect 0x0000000000018000.
REQ-030 SHALL test 0x43E0000000000000 (2^63): expect 0x7FFFFFFFFFFFFFFF, flags 01; 0xC3E0000000000000: expect 0x8000000000000000, flags 00; 0xFFF0000000000000: expect 0x8000000000000000, flags 01.
REQ-031 SHALL test 0x7FF8000000000000 (NaN): expect 0, flags 10; 0x8000000000000000 and 0x0000000000000001: expect 0, flags 00.
REQ-032 SHALL stream 16 back-to-back values with random tready: outputs match a reference model in order, and tdata stays stable during stalls.
REQ-033 SHALL assert aresetn for 1 cycle with 3 operands in flight: tvalid is low the next cycle, none of the 3 ever appear, and a following operand emerges after 4 cycles.
